// File: rtl/template_match_mem.sv
// template_match_mem: stores an NUM_PIX-pixel training template and, in detect
// mode, streams per-pixel XOR differences against it. It also accumulates a
// Hamming-distance score per frame and decides match/no-match at end of frame.
//
// Handshake: valid-only streaming with no back-pressure. A pixel is accepted on
// every clock edge where i_pix_valid=1 and i_reset=0. o_diff_valid and
// o_result_valid are single-cycle pulses, and downstream logic must take the
// data in that cycle.
module template_match_mem #(
    parameter int DATA_W  = 8,
    parameter int NUM_PIX = 64,
    parameter int ADDR_W  = 6,
    parameter int SCORE_W = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_mode,
    input  logic               i_frame_start,
    input  logic               i_pix_valid,
    input  logic [DATA_W-1:0]  i_pix_data,
    input  logic [SCORE_W-1:0] i_threshold,
    output logic [DATA_W-1:0]  o_diff_data,
    output logic               o_diff_valid,
    output logic               o_done_training,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_result_valid,
    output logic               o_match
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

    logic [DATA_W-1:0]  tmpl_q [NUM_PIX];

    logic               mode_q,         mode_d;
    logic [ADDR_W-1:0]  addr_q,         addr_d;
    logic [SCORE_W-1:0] acc_q,          acc_d;
    logic [DATA_W-1:0]  diff_data_q,    diff_data_d;
    logic               diff_valid_q,   diff_valid_d;
    logic               done_q,         done_d;
    logic [SCORE_W-1:0] score_q,        score_d;
    logic               result_valid_q, result_valid_d;
    logic               match_q,        match_d;

    logic               restart;
    logic [ADDR_W-1:0]  cur_addr;
    logic [SCORE_W-1:0] cur_acc;
    logic               train_wr;
    logic               det_pix;
    logic               last_pix;
    logic [DATA_W-1:0]  diff;
    logic [SCORE_W-1:0] pop;
    logic [SCORE_W-1:0] sum;

    // Frame bookkeeping: restart handling, template compare, and next-state values.
    always_comb begin
        // A frame start or a mode change restarts the frame this very cycle.
        // A pixel arriving now is therefore pixel 0 of the new frame.
        restart  = i_frame_start || (i_mode != mode_q);
        cur_addr = restart ? '0 : addr_q;
        cur_acc  = restart ? '0 : acc_q;
        train_wr = i_pix_valid && !i_mode;
        det_pix  = i_pix_valid && i_mode && done_q;
        last_pix = (cur_addr == LAST_ADDR);

        diff = i_pix_data ^ tmpl_q[cur_addr];
        pop  = '0;
        for (int i = 0; i < DATA_W; i++) begin
            pop = pop + SCORE_W'(diff[i]);
        end
        sum = cur_acc + pop;

        mode_d         = i_mode;
        addr_d         = cur_addr;
        acc_d          = cur_acc;
        diff_data_d    = diff_data_q;
        diff_valid_d   = 1'b0;
        done_d         = done_q;
        score_d        = score_q;
        result_valid_d = 1'b0;
        match_d        = match_q;

        // Detect pixels before training is done are ignored and do not advance the address.
        if (train_wr || det_pix) begin
            addr_d = last_pix ? '0 : cur_addr + 1'b1;
        end

        if (train_wr && last_pix) begin
            done_d = 1'b1;
        end

        if (det_pix) begin
            diff_data_d  = diff;
            diff_valid_d = 1'b1;
            acc_d        = sum;
            if (last_pix) begin
                acc_d          = '0;
                score_d        = sum;
                match_d        = (sum <= i_threshold);
                result_valid_d = 1'b1;
            end
        end
    end

    // Control and output registers; reset captures the current mode so no restart follows reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mode_q         <= i_mode;
            addr_q         <= '0;
            acc_q          <= '0;
            diff_data_q    <= '0;
            diff_valid_q   <= 1'b0;
            done_q         <= 1'b0;
            score_q        <= '0;
            result_valid_q <= 1'b0;
            match_q        <= 1'b0;
        end else begin
            mode_q         <= mode_d;
            addr_q         <= addr_d;
            acc_q          <= acc_d;
            diff_data_q    <= diff_data_d;
            diff_valid_q   <= diff_valid_d;
            done_q         <= done_d;
            score_q        <= score_d;
            result_valid_q <= result_valid_d;
            match_q        <= match_d;
        end
    end

    // Template storage: no reset; writes only from accepted train pixels.
    always_ff @(posedge i_clk) begin
        if (!i_reset && train_wr) begin
            tmpl_q[cur_addr] <= i_pix_data;
        end
    end

    assign o_diff_data     = diff_data_q;
    assign o_diff_valid    = diff_valid_q;
    assign o_done_training = done_q;
    assign o_score         = score_q;
    assign o_result_valid  = result_valid_q;
    assign o_match         = match_q;

endmodule

// File: doc/template_match_mem.md
Name: template_match_mem

Overview:
- Parametrised successor to the single-pixel XOR memory cell. Stores a full NUM_PIX-pixel training template instead of one pixel.
- In detect mode, it streams per-pixel XOR differences against the stored template.
- It accumulates a Hamming-distance score per frame and issues a match/no-match decision against a runtime threshold at end of frame.
- Sits between the pixel stream source and the detector decision logic.

Parameters:
DATA_W, 8, pixel width in bits
NUM_PIX, 64, pixels per frame / template depth
ADDR_W, 6, pixel address width; must satisfy 2**ADDR_W >= NUM_PIX
SCORE_W, 16, score width; must satisfy 2**SCORE_W > NUM_PIX*DATA_W

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_mode  in  1  0 = train, 1 = detect
i_frame_start  in  1  restart frame: pixel address 0, accumulator cleared
i_pix_valid  in  1  pixel data valid this cycle
i_pix_data  in  DATA_W  incoming pixel
i_threshold  in  SCORE_W  maximum score still counted as a match
o_diff_data  out  DATA_W  i_pix_data XOR template[addr], registered
o_diff_valid  out  1  o_diff_data valid, one-cycle pulse per pixel
o_done_training  out  1  sticky: a full template frame has been written
o_score  out  SCORE_W  final Hamming distance of last detect frame
o_result_valid  out  1  one-cycle pulse: o_score/o_match updated
o_match  out  1  o_score <= threshold

Behaviour:
- Reset: all outputs 0; pixel address and accumulator cleared; mode_q captures i_mode. Template contents are not reset; o_done_training=0 forces retraining.
- Template storage:
  - Register array / distributed RAM, NUM_PIX x DATA_W.
  - Combinational read at the current address.
  - Write on accepted train pixel.
- Accepted pixel: i_pix_valid=1 and not in reset.
- Pixel address:
  - Increments on each accepted pixel.
  - Wraps NUM_PIX-1 -> 0; the pixel at NUM_PIX-1 is the last of the frame.
- i_frame_start=1:
  - Address forced to 0 and accumulator cleared this cycle.
  - If a pixel is also accepted, it is treated as pixel 0 and the address becomes 1 next cycle.
- Mode change (i_mode != mode_q): address and accumulator cleared as for i_frame_start; mode_q updated. Any pixel accepted in that cycle is processed in the new mode as pixel 0.
- Train mode (i_mode=0):
  - Each accepted pixel is written to template[addr]; o_diff_valid stays 0.
  - On acceptance of pixel NUM_PIX-1, o_done_training <= 1 (sticky until reset).
  - Retraining at any time overwrites the template; o_done_training stays 1.
- Detect mode (i_mode=1) with o_done_training=1:
  - Next cycle: o_diff_data <= i_pix_data ^ template[addr], o_diff_valid <= 1.
  - Accumulator += popcount(diff), result width SCORE_W.
  - On pixel NUM_PIX-1:
    - o_score <= acc + popcount(diff).
    - o_match <= (that sum <= i_threshold), using i_threshold sampled in the same cycle.
    - o_result_valid <= 1 for one cycle.
    - Accumulator <= 0.
  - Latency: diff and result both appear 1 cycle after acceptance.
- Detect mode with o_done_training=0: pixels ignored; address does not advance; no valid outputs.
- o_diff_valid and o_result_valid are 0 in every cycle not described above.
- o_score and o_match hold their value until the next result.
- Reset mid-frame: partial frame discarded; no result pulse.
- Gaps (i_pix_valid=0) anywhere in a frame: address and accumulator hold.

Test Plan:
1. Bench parameters NUM_PIX=4, DATA_W=8. Reset, then detect-mode pixels 0x11 x4 -> no o_diff_valid, no o_result_valid, o_done_training=0.
2. Train 0x00,0xFF,0x0F,0xA5 -> o_done_training=1 one cycle after the 4th pixel, no diff pulses. Detect the same four pixels, threshold 0 -> diffs all 0x00; o_score=0, o_match=1, o_result_valid pulses once, 1 cycle after the 4th pixel.
3. Detect 0xFF,0xFF,0xFF,0xFF, threshold 15 -> diffs 0xFF,0x00,0xF0,0x5A; o_score=8+0+4+4=16, o_match=0. Repeat with threshold 16 -> o_match=1.
4. Detect two pixels, assert i_frame_start with a third pixel, then send three more -> the first two pixels are excluded; a single result after pixel 4 of the new frame; address wrap is correct.
5. Reset after two detect pixels, then retrain and detect a full frame -> no result pulse from the aborted frame; o_done_training=0 until retrain completes.
6. Mode switch train->detect mid-frame, and detect frames with i_pix_valid gaps -> address restarts at 0 on the switch; the score is unaffected by gaps.
